// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port word RAM between an instruction-fetch port
// and a data port. Data wins ties, bounded by a streak limit so fetch cannot starve.
module mem_arbiter #(
    parameter int DSTREAK_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic [31:0] mem_a,
    output logic        mem_we,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic {GNT_I, GNT_D} gnt_t;

    localparam logic [2:0] STREAK_LIM = 3'(DSTREAK_MAX);

    state_t      state, state_nx;
    gnt_t        gnt, gnt_nx;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        we_q;
    logic [2:0]  streak;
    logic        take_i;
    logic        take_d;

    // In RESP the just-served port is ineligible, so only the other port can be taken.
    always_comb begin
        state_nx = state;
        gnt_nx   = gnt;
        take_i   = 1'b0;
        take_d   = 1'b0;
        case (state)
            IDLE: begin
                if (d_req && !(i_req && streak == STREAK_LIM)) take_d = 1'b1;
                else if (i_req)                                 take_i = 1'b1;
            end
            ACCESS: state_nx = RESP;
            RESP: begin
                state_nx = IDLE;
                if (gnt == GNT_D && i_req)      take_i = 1'b1;
                else if (gnt == GNT_I && d_req) take_d = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
        if (take_d) begin
            state_nx = ACCESS;
            gnt_nx   = GNT_D;
        end else if (take_i) begin
            state_nx = ACCESS;
            gnt_nx   = GNT_I;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            gnt     <= GNT_I;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            we_q    <= 1'b0;
            streak  <= 3'd0;
            i_rdata <= 32'd0;
            d_rdata <= 32'd0;
        end else begin
            state <= state_nx;
            gnt   <= gnt_nx;
            if (take_d) begin
                addr_q  <= d_addr;
                wdata_q <= d_wdata;
                we_q    <= d_we;
                if (!i_req)                    streak <= 3'd0;
                else if (streak != STREAK_LIM) streak <= streak + 3'd1;
            end else if (take_i) begin
                // Fetch never writes; wdata is left alone so mem_wd does not toggle.
                addr_q <= i_addr;
                we_q   <= 1'b0;
                streak <= 3'd0;
            end
            if (state == ACCESS) begin
                if (gnt == GNT_D) d_rdata <= mem_rd;
                else              i_rdata <= mem_rd;
            end
        end
    end

    assign mem_a   = addr_q;
    assign mem_wd  = wdata_q;
    assign mem_we  = (state == ACCESS) && (gnt == GNT_D) && we_q && !reset;
    assign i_ready = (state == RESP) && (gnt == GNT_I);
    assign d_ready = (state == RESP) && (gnt == GNT_D);
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic, checked every cycle
// against a transaction-level model of the arbiter and its RAM.
module tb_mem_arbiter;

    localparam int DSTREAK_MAX = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic        i_ready, d_ready, mem_we, busy;
    logic [31:0] i_rdata, d_rdata, mem_a, mem_wd, mem_rd;

    int nchecks = 0;
    int npass   = 0;
    bit cmp_on  = 1'b0;

    mem_arbiter #(.DSTREAK_MAX(DSTREAK_MAX)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] initWord(input int k);
        if (k == 2) return 32'h2002_0005;
        return 32'hC0DE_0000 | 32'(k);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nchecks++;
        if (actual === expected) npass++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    task automatic failTimeout(input string name, input int waited);
        nchecks++;
        $display("[TB] FAIL %s: waited %0d cycles, required completion within 40", name, waited);
    endtask

    // Environment RAM seen by the DUT
    logic [31:0] ram [0:255];
    initial begin
        for (int k = 0; k < 256; k++) ram[k] = initWord(k);
        forever begin
            @(posedge clk);
            if (mem_we) ram[mem_a[9:2]] <= mem_wd;
        end
    end
    assign mem_rd = ram[mem_a[9:2]];

    // Reference model: one outstanding transaction, phase 0 idle / 1 memory cycle / 2 reply
    logic [31:0] model_mem [0:255];
    int          m_phase = 0;
    bit          m_who = 1'b0;
    bit          m_we = 1'b0;
    bit          m_dknown = 1'b1;
    logic [31:0] m_addr = 32'd0, m_wd = 32'd0, m_irdata = 32'd0, m_drdata = 32'd0;
    int          m_streak = 0;

    initial begin
        for (int k = 0; k < 256; k++) model_mem[k] = initWord(k);
        forever begin
            bit want_i, want_d;
            @(posedge clk);
            want_i = 1'b0;
            want_d = 1'b0;
            if (reset) begin
                m_phase = 0; m_who = 1'b0; m_we = 1'b0; m_streak = 0;
                m_addr = 32'd0; m_wd = 32'd0; m_irdata = 32'd0; m_drdata = 32'd0; m_dknown = 1'b1;
            end else begin
                if (m_phase == 0) begin
                    if (d_req && !(i_req && m_streak == DSTREAK_MAX)) want_d = 1'b1;
                    else if (i_req) want_i = 1'b1;
                end else if (m_phase == 1) begin
                    if (m_who) begin
                        m_drdata = model_mem[m_addr[9:2]];
                        m_dknown = !m_we;
                        if (m_we) model_mem[m_addr[9:2]] = m_wd;
                    end else begin
                        m_irdata = model_mem[m_addr[9:2]];
                    end
                    m_phase = 2;
                end else begin
                    m_phase = 0;
                    if (m_who && i_req) want_i = 1'b1;
                    else if (!m_who && d_req) want_d = 1'b1;
                end
                if (want_d) begin
                    m_who = 1'b1; m_addr = d_addr; m_wd = d_wdata; m_we = d_we; m_phase = 1;
                    m_streak = i_req ? ((m_streak < DSTREAK_MAX) ? m_streak + 1 : m_streak) : 0;
                end else if (want_i) begin
                    m_who = 1'b0; m_addr = i_addr; m_we = 1'b0; m_phase = 1; m_streak = 0;
                end
            end
        end
    end

    // Per-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        if (cmp_on) begin
            checkOutput("busy", {31'b0, busy}, {31'b0, m_phase != 0});
            checkOutput("i_ready", {31'b0, i_ready}, {31'b0, m_phase == 2 && !m_who});
            checkOutput("d_ready", {31'b0, d_ready}, {31'b0, m_phase == 2 && m_who});
            checkOutput("mem_we", {31'b0, mem_we}, {31'b0, m_phase == 1 && m_who && m_we && !reset});
            checkOutput("mem_a", mem_a, m_addr);
            checkOutput("mem_wd", mem_wd, m_wd);
            checkOutput("i_rdata", i_rdata, m_irdata);
            if (m_dknown) checkOutput("d_rdata", d_rdata, m_drdata);
        end
    end

    bit i_seen, d_seen;
    int i_wait, d_wait;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // One cycle of requester behaviour: hold until ready, then drop or re-issue
    task automatic applyStimulus(input bit allow_new);
        if (i_req && i_seen) begin
            i_wait = 0;
            if (allow_new && $urandom_range(0, 1) == 1) i_addr = 32'($urandom_range(0, 1023));
            else i_req = 1'b0;
        end else if (!i_req) begin
            if (allow_new && $urandom_range(0, 3) == 0) begin
                i_req = 1'b1;
                i_addr = 32'($urandom_range(0, 1023));
            end
        end else begin
            i_wait++;
            if (i_wait > 40) begin failTimeout("i_req wait", i_wait); i_req = 1'b0; i_wait = 0; end
        end
        i_seen = i_ready;
        if (d_req && d_seen) begin
            d_wait = 0;
            if (allow_new && $urandom_range(0, 1) == 1) begin
                d_addr = 32'($urandom_range(0, 1023)); d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom;
            end else d_req = 1'b0;
        end else if (!d_req) begin
            if (allow_new && $urandom_range(0, 2) == 0) begin
                d_req = 1'b1;
                d_addr = 32'($urandom_range(0, 1023)); d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom;
            end
        end else begin
            d_wait++;
            if (d_wait > 40) begin failTimeout("d_req wait", d_wait); d_req = 1'b0; d_wait = 0; end
        end
        d_seen = d_ready;
        reset = allow_new && ($urandom_range(0, 99) == 0);
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            tick();
            applyStimulus(1'b0);
            if (!i_req && !d_req && !busy) done = 1'b1;
        end
        if (!done) failTimeout("drain", 40);
    endtask

    initial begin
        int icnt, dcnt, first_ready, bad;
        reset = 1'b1; i_req = 1'b0; i_addr = 32'd0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
        tick(); tick();
        checkOutput("reset busy", {31'b0, busy}, 32'd0);
        checkOutput("reset ready", {30'b0, i_ready, d_ready}, 32'd0);
        checkOutput("reset mem_we", {31'b0, mem_we}, 32'd0);
        checkOutput("reset mem_a", mem_a, 32'd0);
        checkOutput("reset mem_wd", mem_wd, 32'd0);
        checkOutput("reset i_rdata", i_rdata, 32'd0);
        checkOutput("reset d_rdata", d_rdata, 32'd0);
        cmp_on = 1'b1;
        reset = 1'b0;
        tick();

        $display("[TB] fetch only");
        i_req = 1'b1; i_addr = 32'h08;
        tick(); checkOutput("fetch mem_a", mem_a, 32'h08);
        tick(); checkOutput("fetch i_ready", {31'b0, i_ready}, 32'd1);
                checkOutput("fetch i_rdata", i_rdata, 32'h2002_0005);
        tick(); checkOutput("fetch pulse ends", {31'b0, i_ready}, 32'd0);
        i_req = 1'b0;

        $display("[TB] data write then read");
        tick();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h54; d_wdata = 32'h7;
        tick(); checkOutput("write mem_we", {31'b0, mem_we}, 32'd1);
                checkOutput("write mem_wd", mem_wd, 32'h7);
        tick(); checkOutput("write d_ready", {31'b0, d_ready}, 32'd1);
        tick(); checkOutput("ram[21] written", ram[21], 32'h7);
        d_we = 1'b0;
        tick(); tick();
        checkOutput("read d_ready", {31'b0, d_ready}, 32'd1);
        checkOutput("read d_rdata", d_rdata, 32'h7);
        tick(); d_req = 1'b0;

        $display("[TB] simultaneous requests");
        tick();
        i_req = 1'b1; i_addr = 32'h0C; d_req = 1'b1; d_addr = 32'h54;
        tick(); checkOutput("tie D first", mem_a, 32'h54);
        tick(); checkOutput("tie d_ready", {30'b0, i_ready, d_ready}, 32'd1);
        tick(); d_req = 1'b0;
                checkOutput("tie I next", mem_a, 32'h0C);
        tick(); checkOutput("tie i_ready", {30'b0, i_ready, d_ready}, 32'd2);
                checkOutput("tie i_rdata", i_rdata, 32'hC0DE_0003);
        tick(); i_req = 1'b0;

        $display("[TB] both held");
        tick();
        i_req = 1'b1; i_addr = 32'h20; d_req = 1'b1; d_addr = 32'h54;
        icnt = 0; dcnt = 0; first_ready = -1;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (d_ready) begin dcnt++; if (first_ready < 0) first_ready = 1; end
            if (i_ready) begin icnt++; if (first_ready < 0) first_ready = 0; end
        end
        checkOutput("held first ready D", 32'(first_ready), 32'd1);
        checkOutput("held d_ready count", 32'(dcnt), 32'd4);
        checkOutput("held i_ready count", 32'(icnt), 32'd4);
        i_seen = 1'b0; d_seen = 1'b0; i_wait = 0; d_wait = 0;
        drain();

        $display("[TB] reset during write");
        tick();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hDEAD;
        tick(); reset = 1'b1; #1;
        checkOutput("reset blocks mem_we", {31'b0, mem_we}, 32'd0);
        tick(); checkOutput("abort busy", {31'b0, busy}, 32'd0);
                checkOutput("abort d_ready", {31'b0, d_ready}, 32'd0);
                checkOutput("ram[4] intact", ram[4], 32'hC0DE_0004);
        reset = 1'b0;
        tick(); checkOutput("fresh grant mem_a", mem_a, 32'h10);
        tick(); checkOutput("fresh d_ready", {31'b0, d_ready}, 32'd1);
                checkOutput("ram[4] written", ram[4], 32'h0000_DEAD);
        tick(); d_req = 1'b0; d_we = 1'b0;

        $display("[TB] idle stability");
        for (int k = 0; k < 10; k++) begin
            tick();
            checkOutput("idle mem_we", {31'b0, mem_we}, 32'd0);
            checkOutput("idle busy", {31'b0, busy}, 32'd0);
            checkOutput("idle mem_a", mem_a, 32'h10);
        end

        $display("[TB] random traffic");
        i_seen = 1'b0; d_seen = 1'b0; i_wait = 0; d_wait = 0;
        for (int k = 0; k < 3000; k++) begin
            tick();
            applyStimulus(1'b1);
        end
        drain();
        tick();

        bad = 0;
        for (int k = 0; k < 256; k++) if (ram[k] !== model_mem[k]) bad++;
        checkOutput("ram image differences", 32'(bad), 32'd0);

        $display("%0d/%0d checks passed", npass, nchecks);
        $finish;
    end

endmodule
